cajero_automatico: RTL
======================

CAJERO_AUTOMATICO -- requirements
Module: cajero_automatico

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: TARJETA_RECIBIDA  in  1  level, card present.
REQ-004 SHALL have: TIPO_TRANS  in  1  0 = deposito, 1 = retiro; sampled with MONTO_STB.
REQ-005 SHALL have: DIGITO_STB  in  1  one-cycle strobe qualifying DIGITO.
REQ-006 SHALL have: DIGITO  in  4  decimal PIN digit, most significant digit first.
REQ-007 SHALL have: PIN  in  16  correct PIN, binary value 0..9999.
REQ-008 SHALL have: MONTO_STB  in  1  one-cycle strobe qualifying MONTO.
REQ-009 SHALL have: MONTO  in  32  unsigned transaction amount.
REQ-010 SHALL have: BALANCE_INICIAL  in  64  account balance, loaded on card insertion.
REQ-011 SHALL have outputs: ENTREGAR_DINERO, PIN_INCORRECTO, FONDOS_INSUFICIENTES, BALANCE_ACTUALIZADO (1-bit pulses); ADVERTENCIA, BLOQUEO (1-bit levels); BALANCE  out  64  current balance.

Function
REQ-012 SHALL implement states ESPERA_TARJETA, INGRESO_PIN, ESPERA_MONTO, BLOQUEADO; all outputs registered.
REQ-013 ESPERA_TARJETA: TARJETA_RECIBIDA=1 SHALL load BALANCE <= BALANCE_INICIAL, clear digit counter/accumulator, go INGRESO_PIN next cycle.
REQ-014 INGRESO_PIN: each DIGITO_STB with DIGITO<=9 SHALL do acc <= acc*10 + DIGITO (16-bit) and count++; DIGITO 10..15 strobes SHALL be ignored.
REQ-015 On 4th accepted digit, comparison SHALL use the completed value; result visible the following cycle.
REQ-016 acc == PIN: SHALL clear failure counter and ADVERTENCIA, go ESPERA_MONTO.
REQ-017 acc != PIN: SHALL pulse PIN_INCORRECTO one cycle, increment failure counter (2 bits), clear acc/count, stay INGRESO_PIN.
REQ-018 Second consecutive failure SHALL additionally set ADVERTENCIA=1 (held).
REQ-019 Third consecutive failure SHALL set BLOQUEO=1, enter BLOQUEADO; BLOQUEADO SHALL be left only by reset, ignoring all inputs.
REQ-020 ESPERA_MONTO, MONTO_STB with TIPO_TRANS=0: BALANCE <= BALANCE + zero-extended MONTO, saturating at 2^64-1; pulse BALANCE_ACTUALIZADO; go ESPERA_TARJETA.
REQ-021 TIPO_TRANS=1 and MONTO <= BALANCE: BALANCE <= BALANCE - MONTO; pulse ENTREGAR_DINERO and BALANCE_ACTUALIZADO same cycle; go ESPERA_TARJETA.
REQ-022 TIPO_TRANS=1 and MONTO > BALANCE: pulse FONDOS_INSUFICIENTES only; BALANCE unchanged; go ESPERA_TARJETA.
REQ-023 MONTO=0 SHALL be a valid transaction (retiro of 0 pulses ENTREGAR_DINERO).
REQ-024 All pulses SHALL assert exactly one cycle, in the cycle after the qualifying strobe/4th digit is sampled.
REQ-025 DIGITO_STB outside INGRESO_PIN and MONTO_STB outside ESPERA_MONTO SHALL be ignored; both strobes in one cycle: only the one valid for current state acts.
REQ-026 TARJETA_RECIBIDA=0 in INGRESO_PIN or ESPERA_MONTO SHALL abort to ESPERA_TARJETA next cycle, no pulses, failure counter and ADVERTENCIA kept.
REQ-027 After a transaction, a new card cycle SHALL require TARJETA_RECIBIDA observed in ESPERA_TARJETA (a still-high level restarts immediately).

Reset
REQ-028 rst=0 SHALL immediately force ESPERA_TARJETA, BALANCE=0, acc=0, counters=0, all 1-bit outputs 0, regardless of clk.
REQ-029 Reset asserted mid-transaction SHALL discard the transaction with no pulse emitted.

Verification
REQ-030 PIN=1194, BALANCE_INICIAL=20000, card, digits 1,1,9,4, retiro MONTO=5000 -> ENTREGAR_DINERO and BALANCE_ACTUALIZADO one-cycle pulse, BALANCE=15000.
REQ-031 Same setup, deposito MONTO=3000 -> BALANCE_ACTUALIZADO pulse, BALANCE=23000, ENTREGAR_DINERO stays 0.
REQ-032 Retiro MONTO=20001 with BALANCE=20000 -> FONDOS_INSUFICIENTES pulse, BALANCE=20000; MONTO=20000 -> BALANCE=0, ENTREGAR_DINERO pulse.
REQ-033 Digits 1,1,9,5 three times -> PIN_INCORRECTO pulses ×3, ADVERTENCIA=1 after 2nd, BLOQUEO=1 after 3rd; correct PIN afterwards ignored until rst=0.
REQ-034 Wrong PIN once, then 1,1,9,4 -> one PIN_INCORRECTO, ADVERTENCIA=0, ESPERA_MONTO reached; DIGITO=12 strobe mid-entry ignored.
REQ-035 rst=0 between clock edges during ESPERA_MONTO -> BALANCE=0, all outputs 0 immediately; subsequent MONTO_STB produces no pulse.

Source files
------------

// File: rtl/cajero_automatico.sv
// Automatic teller controller: card insertion, 4-digit PIN entry with
// three-strike lockout, and deposit/withdrawal against a 64-bit balance.
module cajero_automatico (
    input  logic        clk,
    input  logic        rst,
    input  logic        TARJETA_RECIBIDA,
    input  logic        TIPO_TRANS,
    input  logic        DIGITO_STB,
    input  logic [3:0]  DIGITO,
    input  logic [15:0] PIN,
    input  logic        MONTO_STB,
    input  logic [31:0] MONTO,
    input  logic [63:0] BALANCE_INICIAL,
    output logic        ENTREGAR_DINERO,
    output logic        PIN_INCORRECTO,
    output logic        FONDOS_INSUFICIENTES,
    output logic        BALANCE_ACTUALIZADO,
    output logic        ADVERTENCIA,
    output logic        BLOQUEO,
    output logic [63:0] BALANCE
);

    localparam int unsigned BAL_W   = 64;
    localparam int unsigned MONTO_W = 32;
    localparam int unsigned PIN_W   = 16;
    localparam int unsigned DIG_W   = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned FAIL_W  = 2;

    localparam logic [DIG_W-1:0]  MAX_DIGITO  = DIG_W'(9);
    localparam logic [CNT_W-1:0]  LAST_DIGITO = CNT_W'(3);
    localparam logic [PIN_W-1:0]  DIEZ        = PIN_W'(10);
    localparam logic [FAIL_W-1:0] ONE_FAIL    = FAIL_W'(1);
    localparam logic [FAIL_W-1:0] TWO_FAILS   = FAIL_W'(2);

    typedef enum logic [1:0] {
        ESPERA_TARJETA = 2'd0,
        INGRESO_PIN    = 2'd1,
        ESPERA_MONTO   = 2'd2,
        BLOQUEADO      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PIN_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [FAIL_W-1:0]   fails_q, fails_d;
    logic [BAL_W-1:0]    balance_q, balance_d;
    logic                advertencia_q, advertencia_d;
    logic                bloqueo_q, bloqueo_d;
    logic                entregar_q, entregar_d;
    logic                pin_inc_q, pin_inc_d;
    logic                fondos_q, fondos_d;
    logic                bal_act_q, bal_act_d;

    // Datapath helpers shared by the next-state logic
    logic                digito_ok_c;
    logic [PIN_W-1:0]    acc_next_c;
    logic                pin_match_c;
    logic [BAL_W:0]      suma_c;
    logic [BAL_W-1:0]    deposito_c;
    logic [BAL_W-1:0]    monto_ext_c;
    logic                alcanza_c;

    // Digit accumulation, saturating deposit sum and withdrawal affordability
    always_comb begin
        digito_ok_c = DIGITO_STB && (DIGITO <= MAX_DIGITO);
        acc_next_c  = PIN_W'(acc_q * DIEZ) + PIN_W'(DIGITO);
        pin_match_c = (acc_next_c == PIN);
        monto_ext_c = BAL_W'(MONTO);
        suma_c      = (BAL_W+1)'(balance_q) + (BAL_W+1)'(monto_ext_c);
        deposito_c  = suma_c[BAL_W] ? {BAL_W{1'b1}} : suma_c[BAL_W-1:0];
        alcanza_c   = (monto_ext_c <= balance_q);
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ESPERA_TARJETA;
            acc_q         <= '0;
            count_q       <= '0;
            fails_q       <= '0;
            balance_q     <= '0;
            advertencia_q <= 1'b0;
            bloqueo_q     <= 1'b0;
            entregar_q    <= 1'b0;
            pin_inc_q     <= 1'b0;
            fondos_q      <= 1'b0;
            bal_act_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            count_q       <= count_d;
            fails_q       <= fails_d;
            balance_q     <= balance_d;
            advertencia_q <= advertencia_d;
            bloqueo_q     <= bloqueo_d;
            entregar_q    <= entregar_d;
            pin_inc_q     <= pin_inc_d;
            fondos_q      <= fondos_d;
            bal_act_q     <= bal_act_d;
        end
    end

    // Next-state and next-output logic; pulses default low every cycle
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        count_d       = count_q;
        fails_d       = fails_q;
        balance_d     = balance_q;
        advertencia_d = advertencia_q;
        bloqueo_d     = bloqueo_q;
        entregar_d    = 1'b0;
        pin_inc_d     = 1'b0;
        fondos_d      = 1'b0;
        bal_act_d     = 1'b0;

        unique case (state_q)
            ESPERA_TARJETA: begin
                if (TARJETA_RECIBIDA) begin
                    balance_d = BALANCE_INICIAL;
                    acc_d     = '0;
                    count_d   = '0;
                    state_d   = INGRESO_PIN;
                end
            end

            INGRESO_PIN: begin
                // Card removal wins over any digit in the same cycle
                if (!TARJETA_RECIBIDA) begin
                    state_d = ESPERA_TARJETA;
                end else if (digito_ok_c) begin
                    if (count_q == LAST_DIGITO) begin
                        acc_d   = '0;
                        count_d = '0;
                        if (pin_match_c) begin
                            fails_d       = '0;
                            advertencia_d = 1'b0;
                            state_d       = ESPERA_MONTO;
                        end else begin
                            pin_inc_d = 1'b1;
                            fails_d   = fails_q + ONE_FAIL;
                            if (fails_q == ONE_FAIL) begin
                                advertencia_d = 1'b1;
                            end
                            if (fails_q == TWO_FAILS) begin
                                bloqueo_d = 1'b1;
                                state_d   = BLOQUEADO;
                            end
                        end
                    end else begin
                        acc_d   = acc_next_c;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end

            ESPERA_MONTO: begin
                if (!TARJETA_RECIBIDA) begin
                    state_d = ESPERA_TARJETA;
                end else if (MONTO_STB) begin
                    state_d = ESPERA_TARJETA;
                    if (!TIPO_TRANS) begin
                        balance_d = deposito_c;
                        bal_act_d = 1'b1;
                    end else if (alcanza_c) begin
                        balance_d  = balance_q - monto_ext_c;
                        entregar_d = 1'b1;
                        bal_act_d  = 1'b1;
                    end else begin
                        fondos_d = 1'b1;
                    end
                end
            end

            BLOQUEADO: begin
                // Only reset leaves this state
                bloqueo_d = 1'b1;
            end

            default: begin
                state_d = ESPERA_TARJETA;
            end
        endcase
    end

    assign ENTREGAR_DINERO      = entregar_q;
    assign PIN_INCORRECTO       = pin_inc_q;
    assign FONDOS_INSUFICIENTES = fondos_q;
    assign BALANCE_ACTUALIZADO  = bal_act_q;
    assign ADVERTENCIA          = advertencia_q;
    assign BLOQUEO              = bloqueo_q;
    assign BALANCE              = balance_q;

endmodule
